// File: rtl/lcd_window_sequencer.sv
// lcd_window_sequencer: streams a window-address command sequence then a pixel burst into byte/pixel serializer slots
module lcd_window_sequencer #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] y1,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [15:0]   pix_data,
  output logic          d8_empty,
  output logic [7:0]    d8_data,
  input  logic          d8_read,
  output logic          d16_empty,
  output logic [15:0]   d16_data,
  input  logic          d16_read,
  input  logic          lcd_busy,
  output logic          lcd_dc,
  output logic          lcd_cs_n,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAITDC = 3'd2, PIX = 3'd3, DRAIN = 3'd4;
  logic [2:0] state;
  logic [3:0] idx;
  logic [15:0] cx0, cx1, cy0, cy1;
  logic [2*CW-1:0] rem;
  logic left;
  logic [CW-1:0] w, h;
  logic bad, tdc, pix_go;
  logic [7:0] byte_val;
  assign w = x1 - x0;
  assign h = y1 - y0;
  assign bad = (x1 < x0) || (y1 < y0);
  // index 11 stands for the pixel phase, which needs data mode
  assign tdc = !(idx == 4'd0 || idx == 4'd5 || idx == 4'd10);
  assign byte_val = idx == 4'd0  ? 8'h2A :
                    idx == 4'd1  ? cx0[15:8] :
                    idx == 4'd2  ? cx0[7:0] :
                    idx == 4'd3  ? cx1[15:8] :
                    idx == 4'd4  ? cx1[7:0] :
                    idx == 4'd5  ? 8'h2B :
                    idx == 4'd6  ? cy0[15:8] :
                    idx == 4'd7  ? cy0[7:0] :
                    idx == 4'd8  ? cy1[15:8] :
                    idx == 4'd9  ? cy1[7:0] : 8'h2C;
  assign pix_ready = (state == PIX) && d16_empty && left;
  assign pix_go = pix_valid && pix_ready;
  assign busy = state != IDLE;
  // rem holds pixels-remaining minus one so the full 2^(2*CW) window fits
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= 4'd0;
      cx0 <= 16'd0;
      cx1 <= 16'd0;
      cy0 <= 16'd0;
      cy1 <= 16'd0;
      rem <= '0;
      left <= 1'b0;
      d8_empty <= 1'b1;
      d16_empty <= 1'b1;
      d8_data <= 8'd0;
      d16_data <= 16'd0;
      lcd_dc <= 1'b1;
      lcd_cs_n <= 1'b1;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (d8_read) d8_empty <= 1'b1;
      if (d16_read) d16_empty <= 1'b1;
      case (state)
        IDLE: if (start) begin
          cx0 <= 16'(x0);
          cx1 <= 16'(x1);
          cy0 <= 16'(y0);
          cy1 <= 16'(y1);
          rem <= (2*CW)'(w) * (2*CW)'(h) + (2*CW)'(w) + (2*CW)'(h);
          idx <= 4'd0;
          left <= !bad;
          err <= bad;
          state <= bad ? IDLE : LOAD;
        end
        LOAD: if (tdc != lcd_dc) state <= WAITDC;
          else if (idx == 4'd11) state <= PIX;
          else if (d8_empty) begin
            d8_data <= byte_val;
            d8_empty <= 1'b0;
            lcd_cs_n <= 1'b0;
            idx <= idx + 4'd1;
          end
        WAITDC: if (d8_empty && d16_empty && !lcd_busy) begin
          lcd_dc <= tdc;
          state <= LOAD;
        end
        PIX: if (pix_go) begin
          d16_data <= pix_data;
          d16_empty <= 1'b0;
          rem <= rem - (2*CW)'(1);
          left <= rem != '0;
          state <= rem == '0 ? DRAIN : PIX;
        end
        DRAIN: if (d16_empty && !lcd_busy) begin
          lcd_cs_n <= 1'b1;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
